// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// through a single full-subtractor cell, controlled by an IDLE/RUN/DONE FSM.
module serial_sub_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             accept;
  logic             step;
  logic             finish;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             borrow;
  logic [CW-1:0]    cnt;

  logic             x_bit;
  logic             y_bit;
  logic             d_bit;
  logic             borrow_next;

  // Single one-bit full-subtractor cell fed by the operand LSBs and borrow.
  assign x_bit       = a_sr[0];
  assign y_bit       = b_sr[0];
  assign d_bit       = x_bit ^ y_bit ^ borrow;
  assign borrow_next = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & borrow);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            finish     = 1'b1;
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Status outputs registered alongside the state transition.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
    end
  end

  // Operand capture, serial shift, and result load on the final bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else if (accept) begin
      a_sr   <= a;
      b_sr   <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {d_bit, res_sr[WIDTH-1:1]};
      borrow <= borrow_next;
      cnt    <= cnt + CW'(1);
      if (finish) begin
        diff <= {d_bit, res_sr[WIDTH-1:1]};
        bout <= borrow_next;
      end
    end
  end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl: transaction-level model plus
// directed literal checks and a randomized phase.
module tb_serial_sub_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         abort;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  // Model: remaining run cycles of the current operation, pending result,
  // and the visible outputs.
  int           m_left;
  logic [W:0]   m_pend;
  logic [W-1:0] m_diff;
  logic         m_bout;
  logic         m_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0;
    m_pend = '0;
    m_diff = '0;
    m_bout = 1'b0;
    m_done = 1'b0;
  endtask

  // One clock edge of the model, using the inputs applied for that edge.
  task automatic model_step();
    bit fin;
    fin = 1'b0;
    if (m_left > 0) begin
      if (abort) begin
        m_left = 0;
      end else begin
        m_left--;
        if (m_left == 0) begin
          m_diff = m_pend[W-1:0];
          m_bout = m_pend[W];
          fin    = 1'b1;
        end
      end
    end else if (start) begin
      m_pend = {1'b0, a} - {1'b0, b} - (W+1)'(bin);
      m_left = W;
    end
    m_done = fin;
  endtask

  // Apply inputs, advance one edge, update the model, settle 1 time unit.
  task automatic cycle(input logic s, input logic ab, input logic [W-1:0] oa,
                       input logic [W-1:0] ob, input logic obin);
    start = s;
    abort = ab;
    a     = oa;
    b     = ob;
    bin   = obin;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Start an operation and wait (bounded) for done; optional re-pulse/abort.
  task automatic op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic obin,
                    input int repulse_at, input int abort_at,
                    output int edges, output int bcnt, output bit seen);
    edges = 0;
    bcnt  = 0;
    seen  = 1'b0;
    cycle(1'b1, 1'b0, oa, ob, obin);
    while (!seen && edges < 12) begin
      if (busy) bcnt++;
      cycle(edges == repulse_at, edges == abort_at, W'($urandom), W'($urandom), 1'($urandom));
      edges++;
      if (done) seen = 1'b1;
    end
  endtask

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("busy", 32'(busy), 32'(m_left > 0));
      chk("done", 32'(done), 32'(m_done));
      chk("diff", 32'(diff), 32'(m_diff));
      chk("bout", 32'(bout), 32'(m_bout));
    end
  end

  initial begin
    int edges;
    int bcnt;
    bit seen;

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_bout", 32'(bout), 32'd0);
    #2 rst_n = 1'b1;
    chk_en = 1'b1;
    cycle(1'b0, 1'b0, '0, '0, 1'b0);

    // Basic subtraction, latency and busy length.
    op(8'h5A, 8'h3C, 1'b0, -1, -1, edges, bcnt, seen);
    chk("t1_latency", 32'(edges), 32'd8);
    chk("t1_busy_cycles", 32'(bcnt), 32'd8);
    chk("t1_diff", 32'(diff), 32'h1E);
    chk("t1_bout", 32'(bout), 32'd0);
    cycle(1'b0, 1'b0, '0, '0, 1'b0);

    // Underflow.
    op(8'h00, 8'h01, 1'b0, -1, -1, edges, bcnt, seen);
    chk("t2_diff", 32'(diff), 32'hFF);
    chk("t2_bout", 32'(bout), 32'd1);
    cycle(1'b0, 1'b0, '0, '0, 1'b0);

    // Borrow-in, then back-to-back start in the DONE cycle.
    op(8'h10, 8'h10, 1'b1, -1, -1, edges, bcnt, seen);
    chk("t3_diff", 32'(diff), 32'hFF);
    chk("t3_bout", 32'(bout), 32'd1);
    op(8'h80, 8'h7F, 1'b0, -1, -1, edges, bcnt, seen);
    chk("t3b_latency", 32'(edges), 32'd8);
    chk("t3b_diff", 32'(diff), 32'h01);
    chk("t3b_bout", 32'(bout), 32'd0);
    cycle(1'b0, 1'b0, '0, '0, 1'b0);

    // Start re-pulsed mid-run is ignored.
    op(8'h33, 8'h11, 1'b0, 3, -1, edges, bcnt, seen);
    chk("t4_latency", 32'(edges), 32'd8);
    chk("t4_diff", 32'(diff), 32'h22);
    cycle(1'b0, 1'b0, '0, '0, 1'b0);
    repeat (10) cycle(1'b0, 1'b0, '0, '0, 1'b0);
    chk("t4_no_queue_busy", 32'(busy), 32'd0);

    // Abort after a prior 0x1E result.
    op(8'h5A, 8'h3C, 1'b0, -1, -1, edges, bcnt, seen);
    cycle(1'b0, 1'b0, '0, '0, 1'b0);
    op(8'hC3, 8'h21, 1'b1, -1, 4, edges, bcnt, seen);
    chk("t5_done_seen", 32'(seen), 32'd0);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_diff", 32'(diff), 32'h1E);

    // Asynchronous reset mid-run.
    cycle(1'b1, 1'b0, 8'h77, 8'h12, 1'b0);
    repeat (3) cycle(1'b0, 1'b0, '0, '0, 1'b0);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_done", 32'(done), 32'd0);
    chk("t6_diff", 32'(diff), 32'd0);
    chk("t6_bout", 32'(bout), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    op(8'hFF, 8'h0F, 1'b0, -1, -1, edges, bcnt, seen);
    chk("t6b_latency", 32'(edges), 32'd8);
    chk("t6b_diff", 32'(diff), 32'hF0);
    chk("t6b_bout", 32'(bout), 32'd0);

    // Randomized traffic with sporadic start/abort.
    for (int i = 0; i < 2000; i++) begin
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0),
            W'($urandom), W'($urandom), 1'($urandom));
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request a subtraction; sampled only in IDLE or DONE.
REQ-005 abort  input  1  synchronous cancel of an operation in progress.
REQ-006 a  input  WIDTH  minuend, captured on the accepting edge.
REQ-007 b  input  WIDTH  subtrahend, captured on the accepting edge.
REQ-008 bin  input  1  initial borrow into bit 0, captured on the accepting edge.
REQ-009 busy  output  1  high while the operation is in RUN.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 diff  output  WIDTH  registered result, a - b - bin modulo 2^WIDTH.
REQ-012 bout  output  1  registered borrow out of the MSB.

Function
REQ-013 The block SHALL compute the difference bit-serially, LSB first, one bit per cycle, through a single one-bit full-subtractor cell: d = x^y^c, borrow = (~x&y) | (~(x^y)&c).
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start=1: capture a, b and bin into shift registers, clear the bit counter, and go to RUN.
REQ-016 RUN: on each edge, process operand bit [cnt], shift the result bit into a result shift register at its MSB end, update the borrow register, and increment cnt.
REQ-017 RUN exit: on the edge that processes bit WIDTH-1, load diff and bout from the result shift register and the final borrow, and go to DONE.
REQ-018 Latency: done SHALL be high in the cycle after the WIDTH-th edge following the accepting edge.
REQ-019 done SHALL be 1 only in DONE; DONE lasts exactly one cycle.
REQ-020 DONE with start=0: go to IDLE.
REQ-021 DONE with start=1: accept a new operation exactly as in IDLE (back-to-back operation, no idle bubble).
REQ-022 start while in RUN SHALL be ignored and SHALL NOT be queued.
REQ-023 abort=1 in RUN: go to IDLE on that edge; diff, bout and done remain unchanged (done stays 0).
REQ-024 abort outside RUN: no effect.
REQ-025 abort and start both high in IDLE or DONE: start takes effect.
REQ-026 diff and bout SHALL hold the last completed result during a subsequent RUN and until the next completion.
REQ-027 The bit counter SHALL be ceil(log2(WIDTH))+1 bits wide and SHALL NOT wrap inside RUN.

Reset
REQ-028 rst_n=0 in any state, including mid-RUN, SHALL immediately force the following: state=IDLE, busy=0, done=0, diff=0, bout=0, counter=0, borrow register=0, operand shift registers=0.
REQ-029 After rst_n deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Verification (WIDTH=8)
REQ-030 Inputs a=0x5A, b=0x3C, bin=0 with a start pulse -> done is high 8 edges later with diff=0x1E and bout=0; busy is high for exactly 8 cycles.
REQ-031 Inputs a=0x00, b=0x01, bin=0 -> diff=0xFF, bout=1.
REQ-032 Inputs a=0x10, b=0x10, bin=1 -> diff=0xFF, bout=1. Back-to-back: start held high in the DONE cycle with a=0x80, b=0x7F, bin=0 -> the next done follows 8 edges later with diff=0x01, bout=0.
REQ-033 start is re-pulsed at RUN cycle 3 with different operands -> it is ignored, and the original result is delivered on schedule.
REQ-034 abort is asserted at RUN cycle 4 after a prior result of 0x1E -> the block returns to IDLE, done never pulses, and diff stays 0x1E.
REQ-035 rst_n is pulled low mid-RUN, asynchronously between edges -> busy, done, diff and bout go to 0 immediately. A following operation with a=0xFF, b=0x0F, bin=0 -> diff=0xF0, bout=0.
